// File: rtl/vga_dac_driver.sv
// vga_dac_driver
// VGA output stage: free-running h/v timing generator, pixel request port
// towards the compositor, registered colour bus to the DAC and sync outputs
// delayed to line up with the external DAC pipeline.
// Counters are 10 bits wide, matching req_x/req_y, so H_TOTAL and V_TOTAL
// must not exceed 1024.

module vga_dac_driver #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int HSYNC_POL     = 0,
    parameter int VSYNC_POL     = 0,
    parameter int R_BITS        = 5,
    parameter int G_BITS        = 6,
    parameter int B_BITS        = 5,
    parameter int PIXEL_LATENCY = 2,
    parameter int SYNC_DELAY    = 7,
    localparam int CW           = R_BITS + G_BITS + B_BITS
) (
    input  logic          clk,
    input  logic          reset,
    output logic [9:0]    req_x,
    output logic [9:0]    req_y,
    output logic          req_active,
    output logic          frame_start,
    input  logic [CW-1:0] pixel_in,
    input  logic          pixel_valid,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] test_colour,
    input  logic          underflow_clear,
    output logic          underflow_sticky,
    output logic [CW-1:0] hw_colour_bus,
    output logic          hw_hsync_out,
    output logic          hw_vsync_out,
    output logic          hw_dacclk_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);

    // Pin level when the sync is asserted
    localparam logic HS_ON = (HSYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ON = (VSYNC_POL != 0) ? 1'b1 : 1'b0;

    localparam logic [CW-1:0] BLACK = {CW{1'b0}};

    // Colour-bar pattern: b = 7 - index, each field all ones when its bit is set,
    // giving white, yellow, magenta, red, cyan, green, blue, black left to right.
    function automatic logic [CW-1:0] bar_colour(input logic [2:0] idx);
        logic [2:0] b;
        b = 3'd7 - idx;
        return {{R_BITS{b[2]}}, {G_BITS{b[1]}}, {B_BITS{b[0]}}};
    endfunction

    // Request-side timing state
    logic [9:0] h_r;
    logic [9:0] v_r;
    logic [9:0] bar_cnt_r;
    logic [2:0] bar_idx_r;
    logic [1:0] mode_r;

    // Delay line aligning request-side attributes with pixel_in
    logic       act_dl_r [PIXEL_LATENCY];
    logic       hs_dl_r  [PIXEL_LATENCY];
    logic       vs_dl_r  [PIXEL_LATENCY];
    logic [2:0] bar_dl_r [PIXEL_LATENCY];

    // Output stage: colour register plus sync pin-level pipeline
    logic [CW-1:0]       colour_r;
    logic [SYNC_DELAY:0] hs_pipe_r;
    logic [SYNC_DELAY:0] vs_pipe_r;
    logic                underflow_r;

    logic          h_wrap_s;
    logic          v_wrap_s;
    logic          active_s;
    logic          hs_flag_s;
    logic          vs_flag_s;
    logic          frame_start_s;
    logic          act_al_s;
    logic          hs_al_s;
    logic          vs_al_s;
    logic [2:0]    bar_al_s;
    logic [CW-1:0] colour_s;
    logic          underflow_set_s;

    assign h_wrap_s      = (h_r == H_LAST);
    assign v_wrap_s      = (v_r == V_LAST);
    assign active_s      = (h_r < H_ACT) && (v_r < V_ACT);
    assign hs_flag_s     = (h_r >= HS_START) && (h_r < HS_END);
    assign vs_flag_s     = (v_r >= VS_START) && (v_r < VS_END);
    assign frame_start_s = (h_r == 10'd0) && (v_r == 10'd0);

    // Oldest delay-line stage lines up with the pixel_in currently on the bus
    assign act_al_s = act_dl_r[PIXEL_LATENCY-1];
    assign hs_al_s  = hs_dl_r[PIXEL_LATENCY-1];
    assign vs_al_s  = vs_dl_r[PIXEL_LATENCY-1];
    assign bar_al_s = bar_dl_r[PIXEL_LATENCY-1];

    // Horizontal/vertical counters; v steps and wraps on the h wrap clock
    always_ff @(posedge clk) begin
        if (reset) begin
            h_r <= 10'd0;
            v_r <= 10'd0;
        end else if (h_wrap_s) begin
            h_r <= 10'd0;
            if (v_wrap_s) begin
                v_r <= 10'd0;
            end else begin
                v_r <= v_r + 10'd1;
            end
        end else begin
            h_r <= h_r + 10'd1;
        end
    end

    // Bar index tracks req_x / (H_ACTIVE/8) by counting, restarting every line
    always_ff @(posedge clk) begin
        if (reset) begin
            bar_cnt_r <= 10'd0;
            bar_idx_r <= 3'd0;
        end else if (h_wrap_s) begin
            bar_cnt_r <= 10'd0;
            bar_idx_r <= 3'd0;
        end else if (h_r < H_ACT) begin
            if (bar_cnt_r == BAR_LAST) begin
                bar_cnt_r <= 10'd0;
                bar_idx_r <= bar_idx_r + 3'd1;
            end else begin
                bar_cnt_r <= bar_cnt_r + 10'd1;
            end
        end else begin
            bar_cnt_r <= bar_cnt_r;
        end
    end

    // Mode is only taken at frame start so a frame is never split between modes
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r <= 2'b11;
        end else if (frame_start_s) begin
            mode_r <= mode;
        end else begin
            mode_r <= mode_r;
        end
    end

    // Shift request attributes PIXEL_LATENCY clocks to meet the returning pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIXEL_LATENCY; i++) begin
                act_dl_r[i] <= 1'b0;
                hs_dl_r[i]  <= 1'b0;
                vs_dl_r[i]  <= 1'b0;
                bar_dl_r[i] <= 3'd0;
            end
        end else begin
            act_dl_r[0] <= active_s;
            hs_dl_r[0]  <= hs_flag_s;
            vs_dl_r[0]  <= vs_flag_s;
            bar_dl_r[0] <= bar_idx_r;
            for (int i = 1; i < PIXEL_LATENCY; i++) begin
                act_dl_r[i] <= act_dl_r[i-1];
                hs_dl_r[i]  <= hs_dl_r[i-1];
                vs_dl_r[i]  <= vs_dl_r[i-1];
                bar_dl_r[i] <= bar_dl_r[i-1];
            end
        end
    end

    // Colour selection and underflow detection for the aligned pixel
    always_comb begin
        colour_s        = BLACK;
        underflow_set_s = 1'b0;
        if (act_al_s) begin
            case (mode_r)
                2'b00: begin
                    if (pixel_valid) begin
                        colour_s = pixel_in;
                    end else begin
                        colour_s        = BLACK;
                        underflow_set_s = 1'b1;
                    end
                end
                2'b01:   colour_s = test_colour;
                2'b10:   colour_s = bar_colour(bar_al_s);
                default: colour_s = BLACK;
            endcase
        end else begin
            colour_s = BLACK;
        end
    end

    // Colour register driving the DAC bus
    always_ff @(posedge clk) begin
        if (reset) begin
            colour_r <= BLACK;
        end else begin
            colour_r <= colour_s;
        end
    end

    // Sync pin levels: stage 0 is in step with the colour register, the
    // remaining SYNC_DELAY stages cover the external DAC pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_pipe_r <= {(SYNC_DELAY + 1){~HS_ON}};
            vs_pipe_r <= {(SYNC_DELAY + 1){~VS_ON}};
        end else begin
            hs_pipe_r[0] <= hs_al_s ? HS_ON : ~HS_ON;
            vs_pipe_r[0] <= vs_al_s ? VS_ON : ~VS_ON;
            for (int i = 1; i <= SYNC_DELAY; i++) begin
                hs_pipe_r[i] <= hs_pipe_r[i-1];
                vs_pipe_r[i] <= vs_pipe_r[i-1];
            end
        end
    end

    // Sticky underflow flag; a new underflow wins over a coincident clear
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow_r <= 1'b0;
        end else if (underflow_set_s) begin
            underflow_r <= 1'b1;
        end else if (underflow_clear) begin
            underflow_r <= 1'b0;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    assign req_x            = h_r;
    assign req_y            = v_r;
    assign req_active       = active_s;
    assign frame_start      = frame_start_s;
    assign underflow_sticky = underflow_r;
    assign hw_colour_bus    = colour_r;
    assign hw_hsync_out     = hs_pipe_r[SYNC_DELAY];
    assign hw_vsync_out     = vs_pipe_r[SYNC_DELAY];
    assign hw_dacclk_out    = clk;

endmodule

// File: doc/vga_dac_driver.md
Name: vga_dac_driver

Overview:
- Parametrised VGA output stage: internal h/v timing generator, pixel request port to the upstream compositor, registered colour bus to the DAC, delayed sync outputs.
- Generalises the fixed 640x480 DAC handler: configurable timing, colour widths, sync polarity, request latency and sync delay.
- Adds test-pattern modes, frame-start pulse and underflow detection.
- Sits between the frame compositor and the external DAC/connector pins.

Parameters:
H_ACTIVE, 640, visible pixels per line (multiple of 8)
H_FP, 16, horizontal front porch, clocks
H_SYNC, 96, hsync width, clocks
H_BP, 48, horizontal back porch, clocks
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vsync width, lines
V_BP, 33, vertical back porch, lines
HSYNC_POL, 0, 0 = hsync active low, 1 = active high
VSYNC_POL, 0, as above for vsync
R_BITS / G_BITS / B_BITS, 5 / 6 / 5, colour field widths; CW = sum, packed {R,G,B}
PIXEL_LATENCY, 2, clocks from request to pixel_in (>=1)
SYNC_DELAY, 7, extra clocks of sync delay relative to colour (>=0), for DAC pipeline alignment

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
req_x  out  10  x of requested pixel (0..H_ACTIVE-1 when req_active)
req_y  out  10  y of requested pixel
req_active  out  1  request coordinate lies in the visible area
frame_start  out  1  one-cycle pulse when the request counter is at (0,0)
pixel_in  in  CW  pixel data, PIXEL_LATENCY clocks after its request
pixel_valid  in  1  qualifies pixel_in
mode  in  2  00 passthrough, 01 solid, 10 colour bars, 11 black
test_colour  in  CW  colour used in solid mode
underflow_clear  in  1  clears underflow_sticky
underflow_sticky  out  1  set if a visible pixel arrived without pixel_valid
hw_colour_bus  out  CW  registered colour to DAC
hw_hsync_out  out  1  hsync, polarity per HSYNC_POL
hw_vsync_out  out  1  vsync, polarity per VSYNC_POL
hw_dacclk_out  out  1  equals clk (direct assign)

Behaviour:
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1), where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - h increments every clock; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps to 0 after V_TOTAL-1, on the same clock as the h wrap.
- Request outputs (req_x, req_y, req_active, frame_start) are combinational from the counter registers.
  - req_active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the full line.
- Reset:
  - h = v = 0.
  - All delay-line stages cleared to inactive / not-active.
  - hw_colour_bus = 0.
  - Syncs at deasserted level (~POL).
  - underflow_sticky = 0.
  - Latched mode = 11 (black) until the first frame_start.
  - The first cycle after reset presents req (0,0) with frame_start = 1.
- Active flag, sync flags and bar index travel in a delay line of PIXEL_LATENCY stages, aligned with pixel_in.
- Colour selection, using the aligned active flag:
  - Inactive: 0.
  - Active, mode 00: pixel_in if pixel_valid, else 0.
  - Active, mode 01: test_colour.
  - Active, mode 10: bars, index = req_x / (H_ACTIVE/8), produced by a bar counter (no divider).
    - b = 7 - index; R/G/B field all ones if b[2]/b[1]/b[0], else zero.
    - Resulting bar order: white, yellow, magenta, red, cyan, green, blue, black.
  - Active, mode 11: 0.
- hw_colour_bus is registered: colour for request cycle t appears at t+PIXEL_LATENCY+1.
- Syncs: a further SYNC_DELAY stages follow the colour register, so the sync for request cycle t appears at t+PIXEL_LATENCY+1+SYNC_DELAY.
- mode is sampled only on frame_start cycles; changes mid-frame take effect next frame.
- Underflow:
  - underflow_sticky sets on any clock where aligned active = 1, latched mode = 00 and pixel_valid = 0.
  - Cleared by underflow_clear; if set and clear occur on the same clock, set wins.
- pixel_valid and pixel_in are ignored outside the aligned active area.
- Reset asserted mid-frame takes effect on the next edge; no partial pixels are emitted afterwards.

Test Plan:
- Small timing (H 8/2/2/2, V 4/1/1/1), PIXEL_LATENCY=2, SYNC_DELAY=1, release reset -> frame_start every 98 clocks; req_x sweeps 0..7; hsync low for h=10..11 of the request counter, seen on the pins 4 clocks later.
- Passthrough: pixel_in = {req_y, req_x} returned 2 clocks after each request, valid = 1 -> hw_colour_bus equals that value 3 clocks after the request; 0 during blanking.
- Mode 10, default 640 timing -> visible pixel x = 0..79 = 0xFFFF, 80..159 = 0xFFE0, 160..239 = 0xF81F, ..., 560..639 = 0x0000.
- Mode switched 00 -> 01 at line 100 (test_colour = 0x1234) -> output unchanged until the next frame_start, then 0x1234 on all visible pixels.
- Drop pixel_valid for one visible pixel in mode 00 -> that pixel = 0 and underflow_sticky = 1; pulse underflow_clear -> 0; clear coincident with a new underflow -> stays 1.
- Assert reset for 1 clock mid-line -> next clock colour = 0, syncs deasserted (high with POL = 0), counters restart at (0,0) with frame_start = 1.
